// File: rtl/rggen_axi4lite_adapter_if.sv
// Shared RgGen access encoding plus the AXI4-Lite and register-bus interfaces
// used by the AXI4-Lite adapter.
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;
endpackage

interface rggen_axi4lite_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;
    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    logic [1:0]               status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );
    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_axi4lite_adapter.sv
// AXI4-Lite slave front-end: serialises one write or read at a time onto the
// RgGen register bus and holds the bus response until the master takes it.
module rggen_axi4lite_adapter
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    rggen_axi4lite_if.slave axi4lite_if,
    rggen_bus_if.master     bus_if,
    output logic [1:0]      o_state
);
    localparam int LSB = $clog2(BUS_WIDTH / 8);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << LSB;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUS_ACCESS = 2'd1,
        RESPONSE   = 2'd2
    } state_e;

    state_e                   r_state;
    logic                     r_last_write;
    logic                     r_valid;
    rggen_access              r_access;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [BUS_WIDTH-1:0]     r_wdata;
    logic [BUS_WIDTH/8-1:0]   r_strobe;
    logic                     r_bvalid;
    logic                     r_rvalid;
    logic [1:0]               r_bresp;
    logic [1:0]               r_rresp;
    logic [BUS_WIDTH-1:0]     r_rdata;

    logic w_write_pending;
    logic w_read_pending;
    logic w_write_win;
    logic w_read_win;

    // On a conflict the type not served last wins; r_last_write starts as read.
    assign w_write_pending = axi4lite_if.awvalid && axi4lite_if.wvalid;
    assign w_read_pending  = axi4lite_if.arvalid;
    assign w_write_win = i_rst_n && (r_state == IDLE) && w_write_pending &&
                         (!w_read_pending || !r_last_write);
    assign w_read_win  = i_rst_n && (r_state == IDLE) && w_read_pending &&
                         (!w_write_pending || r_last_write);

    assign axi4lite_if.awready = w_write_win;
    assign axi4lite_if.wready  = w_write_win;
    assign axi4lite_if.arready = w_read_win;
    assign axi4lite_if.bvalid  = r_bvalid;
    assign axi4lite_if.bresp   = r_bresp;
    assign axi4lite_if.rvalid  = r_rvalid;
    assign axi4lite_if.rresp   = r_rresp;
    assign axi4lite_if.rdata   = r_rdata;

    assign bus_if.valid      = r_valid;
    assign bus_if.access     = r_access;
    assign bus_if.address    = r_address;
    assign bus_if.write_data = r_wdata;
    assign bus_if.strobe     = r_strobe;

    assign o_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_write <= 1'b0;
            r_valid      <= 1'b0;
            r_access     <= RGGEN_READ;
            r_address    <= '0;
            r_wdata      <= '0;
            r_strobe     <= '0;
            r_bvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            r_bresp      <= 2'b00;
            r_rresp      <= 2'b00;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_write_win) begin
                        r_access  <= RGGEN_WRITE;
                        r_address <= axi4lite_if.awaddr & ADDR_MASK;
                        r_wdata   <= axi4lite_if.wdata;
                        r_strobe  <= axi4lite_if.wstrb;
                        r_valid   <= 1'b1;
                        r_state   <= BUS_ACCESS;
                    end else if (w_read_win) begin
                        r_access  <= RGGEN_READ;
                        r_address <= axi4lite_if.araddr & ADDR_MASK;
                        r_wdata   <= '0;
                        r_strobe  <= '0;
                        r_valid   <= 1'b1;
                        r_state   <= BUS_ACCESS;
                    end
                end
                BUS_ACCESS: begin
                    if (bus_if.ready) begin
                        r_valid      <= 1'b0;
                        r_last_write <= (r_access == RGGEN_WRITE);
                        if (r_access == RGGEN_WRITE) begin
                            r_bresp  <= bus_if.status;
                            r_bvalid <= 1'b1;
                        end else begin
                            r_rresp  <= bus_if.status;
                            r_rdata  <= bus_if.read_data;
                            r_rvalid <= 1'b1;
                        end
                        r_state <= RESPONSE;
                    end
                end
                RESPONSE: begin
                    if ((r_bvalid && axi4lite_if.bready) || (r_rvalid && axi4lite_if.rready)) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_axi4lite_adapter.sv
// Directed bench for rggen_axi4lite_adapter: AXI master and register-bus
// responder driven from tasks, expected values written out by hand.
module tb_rggen_axi4lite_adapter;
    import rggen_rtl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    int         n_pass;
    int         n_total;

    rggen_axi4lite_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) axi ();
    rggen_bus_if      #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus ();

    rggen_axi4lite_adapter #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .axi4lite_if (axi.slave),
        .bus_if      (bus.master),
        .o_state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        axi.awvalid = 0; axi.awaddr = '0; axi.awprot = '0;
        axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.bready = 0;
        axi.arvalid = 0; axi.araddr = '0; axi.arprot = '0; axi.rready = 0;
        bus.ready = 0; bus.status = '0; bus.read_data = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits the given cycles with bus.valid high, then completes one access.
    task automatic bus_respond(input int waits, input logic [1:0] st, input logic [31:0] rd);
        repeat (waits) tick();
        bus.ready = 1; bus.status = st; bus.read_data = rd;
        tick();
        bus.ready = 0; bus.status = '0; bus.read_data = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_total++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
        n_total++; if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b0)
            $display("FAIL rst_axi_flags: got %b want 00000", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}); else n_pass++;
        n_total++; if ({axi.bresp, axi.rresp, axi.rdata} !== 36'h0) $display("FAIL rst_axi_data: got %h want 0", {axi.bresp, axi.rresp, axi.rdata}); else n_pass++;
        n_total++; if ({bus.valid, bus.address, bus.write_data, bus.strobe} !== 53'h0)
            $display("FAIL rst_bus: got %h want 0", {bus.valid, bus.address, bus.write_data, bus.strobe}); else n_pass++;
        n_total++; if (bus.access !== RGGEN_READ) $display("FAIL rst_access: got %b want %b", bus.access, RGGEN_READ); else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        axi.awvalid = 1; axi.awaddr = 16'h0014; axi.wvalid = 1; axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF;
        #1;
        n_total++; if ({axi.awready, axi.wready, axi.arready} !== 3'b110) $display("FAIL wr_readys: got %b want 110", {axi.awready, axi.wready, axi.arready}); else n_pass++;
        tick();
        axi.awvalid = 0; axi.wvalid = 0;
        n_total++; if (bus.valid !== 1'b1) $display("FAIL wr_bus_valid: got %b want 1", bus.valid); else n_pass++;
        n_total++; if (bus.address !== 16'h0014) $display("FAIL wr_addr: got %h want 0014", bus.address); else n_pass++;
        n_total++; if (bus.write_data !== 32'hDEADBEEF) $display("FAIL wr_data: got %h want deadbeef", bus.write_data); else n_pass++;
        n_total++; if (bus.strobe !== 4'hF) $display("FAIL wr_strobe: got %h want f", bus.strobe); else n_pass++;
        n_total++; if (bus.access !== RGGEN_WRITE) $display("FAIL wr_access: got %b want %b", bus.access, RGGEN_WRITE); else n_pass++;
        n_total++; if (axi.awready !== 1'b0) $display("FAIL wr_awready_busy: got %b want 0", axi.awready); else n_pass++;
        repeat (2) begin
            tick();
            n_total++; if ({bus.valid, axi.bvalid} !== 2'b10) $display("FAIL wr_wait: got valid/bvalid %b want 10", {bus.valid, axi.bvalid}); else n_pass++;
        end
        bus_respond(0, 2'b00, 32'h0);
        n_total++; if ({bus.valid, axi.bvalid, axi.rvalid} !== 3'b010) $display("FAIL wr_resp_valid: got %b want 010", {bus.valid, axi.bvalid, axi.rvalid}); else n_pass++;
        n_total++; if (axi.bresp !== 2'b00) $display("FAIL wr_bresp: got %0d want 0", axi.bresp); else n_pass++;
        axi.bready = 1;
        tick();
        axi.bready = 0;
        n_total++; if (axi.bvalid !== 1'b0) $display("FAIL wr_bvalid_drop: got %b want 0", axi.bvalid); else n_pass++;
    endtask

    task automatic test_single_read();
        axi.arvalid = 1; axi.araddr = 16'h0022;
        #1;
        n_total++; if ({axi.awready, axi.arready} !== 2'b01) $display("FAIL rd_readys: got %b want 01", {axi.awready, axi.arready}); else n_pass++;
        tick();
        axi.arvalid = 0;
        n_total++; if (bus.address !== 16'h0020) $display("FAIL rd_addr: got %h want 0020", bus.address); else n_pass++;
        n_total++; if ({bus.write_data, bus.strobe} !== 36'h0) $display("FAIL rd_wdata_strobe: got %h want 0", {bus.write_data, bus.strobe}); else n_pass++;
        n_total++; if (bus.access !== RGGEN_READ) $display("FAIL rd_access: got %b want %b", bus.access, RGGEN_READ); else n_pass++;
        bus_respond(1, 2'b10, 32'h12345678);
        n_total++; if ({axi.rvalid, axi.bvalid} !== 2'b10) $display("FAIL rd_rvalid: got %b want 10", {axi.rvalid, axi.bvalid}); else n_pass++;
        n_total++; if (axi.rdata !== 32'h12345678) $display("FAIL rd_rdata: got %h want 12345678", axi.rdata); else n_pass++;
        n_total++; if (axi.rresp !== 2'b10) $display("FAIL rd_rresp: got %0d want 2", axi.rresp); else n_pass++;
        axi.rready = 1;
        tick();
        axi.rready = 0;
        n_total++; if (axi.rvalid !== 1'b0) $display("FAIL rd_rvalid_drop: got %b want 0", axi.rvalid); else n_pass++;
    endtask

    task automatic test_arbitration();
        // AW and AR together, W late: only the read is pending
        apply_reset();
        axi.awvalid = 1; axi.awaddr = 16'h0004; axi.arvalid = 1; axi.araddr = 16'h0008;
        #1;
        n_total++; if ({axi.awready, axi.wready, axi.arready} !== 3'b001) $display("FAIL arb1_first: got %b want 001", {axi.awready, axi.wready, axi.arready}); else n_pass++;
        tick();
        axi.arvalid = 0; axi.wvalid = 1; axi.wdata = 32'h0000_0011; axi.wstrb = 4'h3;
        n_total++; if (bus.access !== RGGEN_READ) $display("FAIL arb1_access: got %b want %b", bus.access, RGGEN_READ); else n_pass++;
        n_total++; if (axi.awready !== 1'b0) $display("FAIL arb1_aw_busy: got %b want 0", axi.awready); else n_pass++;
        bus_respond(0, 2'b00, 32'h0);
        axi.rready = 1; tick(); axi.rready = 0;
        n_total++; if ({axi.awready, axi.wready} !== 2'b11) $display("FAIL arb1_write_next: got %b want 11", {axi.awready, axi.wready}); else n_pass++;
        tick();
        axi.awvalid = 0; axi.wvalid = 0;
        bus_respond(0, 2'b00, 32'h0);
        axi.bready = 1; tick(); axi.bready = 0;

        // All three together after reset: write, then read, then write again
        apply_reset();
        axi.awvalid = 1; axi.awaddr = 16'h0010; axi.wvalid = 1; axi.wdata = 32'h1; axi.wstrb = 4'h1;
        axi.arvalid = 1; axi.araddr = 16'h0030;
        #1;
        n_total++; if ({axi.awready, axi.arready} !== 2'b10) $display("FAIL arb2_first: got %b want 10", {axi.awready, axi.arready}); else n_pass++;
        tick();
        axi.awvalid = 0; axi.wvalid = 0;
        n_total++; if ({bus.access, axi.arready} !== {RGGEN_WRITE, 1'b0}) $display("FAIL arb2_write: got %b want %b", {bus.access, axi.arready}, {RGGEN_WRITE, 1'b0}); else n_pass++;
        bus_respond(0, 2'b00, 32'h0);
        axi.bready = 1; tick(); axi.bready = 0;
        n_total++; if (axi.arready !== 1'b1) $display("FAIL arb2_read_next: got %b want 1", axi.arready); else n_pass++;
        tick();
        axi.arvalid = 0;
        bus_respond(0, 2'b00, 32'h0);
        axi.rready = 1; tick(); axi.rready = 0;
        axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1;
        #1;
        n_total++; if ({axi.awready, axi.arready} !== 2'b10) $display("FAIL arb3_after_read: got %b want 10", {axi.awready, axi.arready}); else n_pass++;
        tick();
        axi.awvalid = 0; axi.wvalid = 0;
        bus_respond(0, 2'b00, 32'h0);
        axi.bready = 1; tick(); axi.bready = 0;
        n_total++; if ({axi.awready, axi.arready} !== 2'b01) $display("FAIL arb4_after_write: got %b want 01", {axi.awready, axi.arready}); else n_pass++;
        tick();
        axi.arvalid = 0;
        bus_respond(0, 2'b00, 32'h0);
        axi.rready = 1; tick(); axi.rready = 0;
    endtask

    task automatic test_rready_backpressure();
        axi.arvalid = 1; axi.araddr = 16'h0040;
        tick();
        axi.araddr = 16'h0044;
        bus_respond(0, 2'b01, 32'hA5A55A5A);
        repeat (5) begin
            n_total++; if ({axi.rvalid, axi.rresp, axi.rdata} !== {1'b1, 2'b01, 32'hA5A55A5A})
                $display("FAIL bp_hold: got %b/%0d/%h want 1/1/a5a55a5a", axi.rvalid, axi.rresp, axi.rdata); else n_pass++;
            n_total++; if (axi.arready !== 1'b0) $display("FAIL bp_arready: got %b want 0", axi.arready); else n_pass++;
            tick();
        end
        axi.rready = 1;
        #1;
        n_total++; if (axi.arready !== 1'b0) $display("FAIL bp_arready_hs: got %b want 0", axi.arready); else n_pass++;
        tick();
        axi.rready = 0;
        n_total++; if ({axi.rvalid, axi.arready} !== 2'b01) $display("FAIL bp_after: got %b want 01", {axi.rvalid, axi.arready}); else n_pass++;
        tick();
        axi.arvalid = 0;
        n_total++; if (bus.address !== 16'h0044) $display("FAIL bp_next_addr: got %h want 0044", bus.address); else n_pass++;
        bus_respond(0, 2'b00, 32'h0);
        axi.rready = 1; tick(); axi.rready = 0;
    endtask

    task automatic test_aw_without_w();
        axi.awvalid = 1; axi.awaddr = 16'h0050;
        repeat (3) begin
            #1;
            n_total++; if ({axi.awready, axi.wready, bus.valid} !== 3'b000) $display("FAIL aw_only: got %b want 000", {axi.awready, axi.wready, bus.valid}); else n_pass++;
            tick();
        end
        axi.wvalid = 1; axi.wdata = 32'h0BADF00D; axi.wstrb = 4'hC;
        #1;
        n_total++; if ({axi.awready, axi.wready} !== 2'b11) $display("FAIL aw_w_join: got %b want 11", {axi.awready, axi.wready}); else n_pass++;
        tick();
        axi.awvalid = 0; axi.wvalid = 0;
        n_total++; if ({axi.awready, axi.wready, bus.valid} !== 3'b001) $display("FAIL aw_w_pulse: got %b want 001", {axi.awready, axi.wready, bus.valid}); else n_pass++;
        n_total++; if ({bus.write_data, bus.strobe} !== {32'h0BADF00D, 4'hC}) $display("FAIL aw_w_data: got %h want 0badf00dc", {bus.write_data, bus.strobe}); else n_pass++;
        bus_respond(0, 2'b11, 32'h0);
        n_total++; if ({axi.bvalid, axi.bresp} !== 3'b111) $display("FAIL aw_w_bresp: got %b want 111", {axi.bvalid, axi.bresp}); else n_pass++;
        axi.bready = 1; tick(); axi.bready = 0;
    endtask

    task automatic test_reset_mid();
        axi.arvalid = 1; axi.araddr = 16'h0060;
        tick();
        axi.arvalid = 0;
        n_total++; if (bus.valid !== 1'b1) $display("FAIL mid_valid_pre: got %b want 1", bus.valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({bus.valid, axi.bvalid, axi.rvalid, axi.arready} !== 4'b0) $display("FAIL mid_flags: got %b want 0000", {bus.valid, axi.bvalid, axi.rvalid, axi.arready}); else n_pass++;
        n_total++; if ({bus.address, state} !== 18'h0) $display("FAIL mid_addr_state: got %h want 0", {bus.address, state}); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if ({bus.valid, axi.rvalid, axi.bvalid} !== 3'b000) $display("FAIL mid_no_stray: got %b want 000", {bus.valid, axi.rvalid, axi.bvalid}); else n_pass++;
        axi.arvalid = 1; axi.araddr = 16'h0008;
        tick();
        axi.arvalid = 0;
        n_total++; if (bus.address !== 16'h0008) $display("FAIL mid_new_addr: got %h want 0008", bus.address); else n_pass++;
        bus_respond(1, 2'b00, 32'hCAFEF00D);
        n_total++; if ({axi.rvalid, axi.bvalid, axi.rdata} !== {2'b10, 32'hCAFEF00D}) $display("FAIL mid_new_read: got %b/%b/%h want 1/0/cafef00d", axi.rvalid, axi.bvalid, axi.rdata); else n_pass++;
        axi.rready = 1; tick(); axi.rready = 0;
        repeat (2) tick();
        n_total++; if ({axi.rvalid, axi.bvalid, bus.valid} !== 3'b000) $display("FAIL mid_quiet: got %b want 000", {axi.rvalid, axi.bvalid, bus.valid}); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_arbitration();
        test_rready_backpressure();
        test_aw_without_w();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
